// File: rtl/osg_pkg.sv
// Shared types and constants for the output-sequence generator channels.
package osg_pkg;

  localparam int OSG_CNT_W = 28;
  localparam int OSG_N_CH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    DELAY_WAIT,
    PULSE_HI,
    PULSE_LO,
    DONE
  } osg_ch_state_t;

endpackage

// File: rtl/osg_rise_det.sv
// Registered rising-edge detector. The history register resets high so a level
// that is already asserted when reset releases is not mistaken for an edge.
module osg_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic trig
);

  logic din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d <= 1'b1;
      trig  <= 1'b0;
    end else begin
      din_d <= din;
      trig  <= din & ~din_d;
    end
  end

endmodule

// File: rtl/osg_channel.sv
// One output-sequence channel: after a start edge, waits DELAY cycles, emits
// N_PULSES pulses of PULSE_W high every PERIOD cycles, then flags completion.
module osg_channel
  import osg_pkg::*;
#(
  parameter int               CNT_W    = OSG_CNT_W,
  parameter int               DELAY    = 50,
  parameter int               PULSE_W  = 10,
  parameter int               PERIOD   = 50,
  parameter logic [CNT_W-1:0] N_PULSES = CNT_W'(4)
) (
  input  logic             ch_clk,
  input  logic             ch_rst_n,
  input  logic             ch_start,
  input  logic             ch_en,
  output logic             ch_out,
  output logic             ch_busy,
  output logic             ch_end_flg,
  output logic [CNT_W-1:0] ch_pulse_cnt
);

  if (DELAY < 1 || PULSE_W < 1 || PERIOD <= PULSE_W || N_PULSES == '0) begin : g_bad_param
    $fatal(1, "osg_channel: illegal parameter combination");
  end

  // Each counter is loaded with (duration - 1) and the transition fires at zero.
  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] HI_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LO_LD  = CNT_W'(PERIOD - PULSE_W - 1);

  osg_ch_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             trig;

  osg_rise_det u_rise_det (
    .clk   (ch_clk),
    .rst_n (ch_rst_n),
    .din   (ch_start),
    .trig  (trig)
  );

  always_ff @(posedge ch_clk or negedge ch_rst_n) begin
    if (!ch_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ch_out       <= 1'b0;
      ch_busy      <= 1'b0;
      ch_end_flg   <= 1'b0;
      ch_pulse_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            ch_pulse_cnt <= '0;
            if (ch_en) begin
              state   <= DELAY_WAIT;
              cnt     <= DLY_LD;
              ch_busy <= 1'b1;
            end else begin
              // Flag is raised one edge later from DONE, so a disabled
              // channel reports completion without ever pulsing.
              state <= DONE;
            end
          end
        end

        DELAY_WAIT, PULSE_HI, PULSE_LO: begin
          if (!ch_start) begin
            state   <= IDLE;
            cnt     <= '0;
            ch_out  <= 1'b0;
            ch_busy <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            case (state)
              PULSE_HI: begin
                state  <= PULSE_LO;
                cnt    <= LO_LD;
                ch_out <= 1'b0;
              end
              PULSE_LO: begin
                if (ch_pulse_cnt < N_PULSES) begin
                  state        <= PULSE_HI;
                  cnt          <= HI_LD;
                  ch_out       <= 1'b1;
                  ch_pulse_cnt <= ch_pulse_cnt + CNT_W'(1);
                end else begin
                  state      <= DONE;
                  cnt        <= '0;
                  ch_busy    <= 1'b0;
                  ch_end_flg <= 1'b1;
                end
              end
              default: begin
                state        <= PULSE_HI;
                cnt          <= HI_LD;
                ch_out       <= 1'b1;
                ch_pulse_cnt <= ch_pulse_cnt + CNT_W'(1);
              end
            endcase
          end
        end

        DONE: begin
          if (!ch_start) begin
            state      <= IDLE;
            ch_end_flg <= 1'b0;
          end else begin
            ch_end_flg <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          ch_out  <= 1'b0;
          ch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osg_channel.sv
// Directed bench: one small-parameter channel for timing detail plus sixteen
// default channels sharing one start level with their end flags ANDed.
module tb_osg_channel;
  import osg_pkg::*;

  localparam int S_DLY = 3;
  localparam int S_PW  = 2;
  localparam int S_PER = 5;
  localparam int S_N   = 3;

  logic clk;
  logic rst_n;

  logic                 s_start, s_en, s_out, s_busy, s_end;
  logic [OSG_CNT_W-1:0] s_cnt;

  logic                 d_start;
  logic [OSG_N_CH-1:0]  d_out, d_busy, d_end;
  logic [OSG_CNT_W-1:0] d_cnt [OSG_N_CH];
  logic                 d_all_end;

  int n_chk = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  osg_channel #(
    .DELAY    (S_DLY),
    .PULSE_W  (S_PW),
    .PERIOD   (S_PER),
    .N_PULSES (OSG_CNT_W'(S_N))
  ) u_small (
    .ch_clk       (clk),
    .ch_rst_n     (rst_n),
    .ch_start     (s_start),
    .ch_en        (s_en),
    .ch_out       (s_out),
    .ch_busy      (s_busy),
    .ch_end_flg   (s_end),
    .ch_pulse_cnt (s_cnt)
  );

  for (genvar g = 0; g < OSG_N_CH; g++) begin : g_ch
    osg_channel u_ch (
      .ch_clk       (clk),
      .ch_rst_n     (rst_n),
      .ch_start     (d_start),
      .ch_en        (1'b1),
      .ch_out       (d_out[g]),
      .ch_busy      (d_busy[g]),
      .ch_end_flg   (d_end[g]),
      .ch_pulse_cnt (d_cnt[g])
    );
  end

  assign d_all_end = &d_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_out(int k);
    return ((k >= S_DLY) && (k < S_DLY + S_N * S_PER) && (((k - S_DLY) % S_PER) < S_PW)) ? 1 : 0;
  endfunction

  function automatic int exp_cnt(int k);
    int n;
    if (k < S_DLY) return 0;
    n = (k - S_DLY) / S_PER + 1;
    return (n > S_N) ? S_N : n;
  endfunction

  function automatic int exp_busy(int k);
    return (k < S_DLY + S_N * S_PER) ? 1 : 0;
  endfunction

  // k = edges after t0 with start still high.
  task automatic step_chk(input int k);
    chk($sformatf("out k=%0d", k),  32'(s_out),  32'(exp_out(k)));
    chk($sformatf("busy k=%0d", k), 32'(s_busy), 32'(exp_busy(k)));
    chk($sformatf("end k=%0d", k),  32'(s_end),  32'(1 - exp_busy(k)));
    chk($sformatf("cnt k=%0d", k),  32'(s_cnt),  32'(exp_cnt(k)));
  endtask

  // Raise start and advance to just after t0 (edge detect registers one edge first).
  task automatic raise_small();
    s_start = 1'b1;
    tick();
    chk("trig not early busy", 32'(s_busy), 32'd0);
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    s_start = 1'b0;
    s_en    = 1'b1;
    d_start = 1'b0;
    tick();
    tick();
    chk("rst out",  32'(s_out),  32'd0);
    chk("rst busy", 32'(s_busy), 32'd0);
    chk("rst end",  32'(s_end),  32'd0);
    chk("rst cnt",  32'(s_cnt),  32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Scenario 1: full burst
    raise_small();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      step_chk(k);
    end
    s_start = 1'b0;
    tick();
    chk("s1 end cleared", 32'(s_end), 32'd0);
    chk("s1 cnt held", 32'(s_cnt), 32'd3);
    tick();

    // Scenario 2: abort during second pulse
    raise_small();
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) tick();
      step_chk(k);
    end
    s_start = 1'b0;
    tick();
    chk("s2 out", 32'(s_out), 32'd0);
    chk("s2 busy", 32'(s_busy), 32'd0);
    chk("s2 end", 32'(s_end), 32'd0);
    chk("s2 cnt", 32'(s_cnt), 32'd2);
    for (int i = 0; i < 12; i++) tick();
    chk("s2 end late", 32'(s_end), 32'd0);
    chk("s2 out late", 32'(s_out), 32'd0);

    // Scenario 3: disabled channel
    s_en = 1'b0;
    raise_small();
    chk("s3 end t0", 32'(s_end), 32'd0);
    chk("s3 cnt cleared", 32'(s_cnt), 32'd0);
    tick();
    chk("s3 end t0+1", 32'(s_end), 32'd1);
    chk("s3 busy t0+1", 32'(s_busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("s3 out i=%0d", i), 32'(s_out), 32'd0);
    end
    chk("s3 busy", 32'(s_busy), 32'd0);
    s_start = 1'b0;
    tick();
    chk("s3 end cleared", 32'(s_end), 32'd0);
    s_en = 1'b1;

    // Scenario 4: start already high through reset release
    rst_n   = 1'b0;
    s_start = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("s4 out", 32'(s_out), 32'd0);
    chk("s4 busy", 32'(s_busy), 32'd0);
    chk("s4 end", 32'(s_end), 32'd0);
    chk("s4 cnt", 32'(s_cnt), 32'd0);
    s_start = 1'b0;
    tick();
    tick();
    raise_small();
    for (int k = 0; k <= 19; k++) begin
      if (k > 0) tick();
      step_chk(k);
    end
    s_start = 1'b0;
    tick();
    chk("s4 end cleared", 32'(s_end), 32'd0);
    tick();

    // Scenario 5: asynchronous reset during a pulse
    raise_small();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      step_chk(k);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5 out", 32'(s_out), 32'd0);
    chk("s5 busy", 32'(s_busy), 32'd0);
    chk("s5 end", 32'(s_end), 32'd0);
    chk("s5 cnt", 32'(s_cnt), 32'd0);
    s_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Scenario 6: sixteen default channels, end-flag AND
    d_start = 1'b1;
    tick();
    tick();
    chk("s6 busy t0", 32'(d_busy), 32'hFFFF);
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (k == 49)  chk("s6 out k49", 32'(d_out), 32'h0000);
      if (k == 50)  chk("s6 out k50", 32'(d_out), 32'hFFFF);
      if (k == 249) begin
        chk("s6 and k249", 32'(d_all_end), 32'd0);
        chk("s6 busy k249", 32'(d_busy), 32'hFFFF);
      end
    end
    chk("s6 end all", 32'(d_end), 32'hFFFF);
    chk("s6 and", 32'(d_all_end), 32'd1);
    chk("s6 busy", 32'(d_busy), 32'h0000);
    chk("s6 cnt0", 32'(d_cnt[0]), 32'd4);
    chk("s6 cnt15", 32'(d_cnt[OSG_N_CH-1]), 32'd4);
    d_start = 1'b0;
    tick();
    chk("s6 and cleared", 32'(d_all_end), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/osg_channel.md
Name: osg_channel

Overview:
- Per-channel output-sequence generator. Sits directly downstream of the start controller and is instantiated 16 times.
- Consumes the global start level (`st_o`). On its rising edge, waits a programmable delay, emits a burst of N pulses, then raises `ch_end_flg`.
- `ch_end_flg` is held until start drops. The start controller ANDs all 16 end flags to time its own shutdown.

Parameters:
- CNT_W, 28, width of all internal cycle counters. Covers 100 000 000 cycles at 50 MHz.
- DELAY, 50, cycles from start edge to first pulse rising edge; ≥1.
- PULSE_W, 10, pulse high time in cycles; ≥1.
- PERIOD, 50, pulse repetition period in cycles; >PULSE_W.
- N_PULSES, 4, pulses per burst; ≥1; width CNT_W.

Ports:
- ch_clk  in  1  system clock, 50 MHz, same domain as the start controller
- ch_rst_n  in  1  asynchronous, active-low reset
- ch_start  in  1  start level from the start controller (`st_o`), synchronous to ch_clk
- ch_en  in  1  channel enable, quasi-static
- ch_out  out  1  registered pulse output
- ch_busy  out  1  high from the start edge until the end flag or an abort
- ch_end_flg  out  1  burst complete; held while ch_start=1
- ch_pulse_cnt  out  CNT_W  pulses emitted in the current or last burst

Behaviour:
- Reset (async, ch_rst_n=0):
  - state=IDLE; ch_out=0, ch_busy=0, ch_end_flg=0, ch_pulse_cnt=0; all counters 0.
  - start_d resets to 1, so ch_start already high at reset release does not trigger.
- Edge detect: trig = ch_start & ~start_d, registered. Define t0 as the ch_clk edge at which trig is first sampled true.
- States and transitions:
  - IDLE: on trig & ch_en -> DELAY_WAIT, ch_busy=1, delay counter loaded. On trig & ~ch_en -> DONE at t0+1 with no pulses, so a disabled channel never blocks the AND.
  - DELAY_WAIT: ch_out rises at edge t0+DELAY, then -> PULSE_HI.
  - PULSE_HI: ch_out=1 for exactly PULSE_W cycles; ch_pulse_cnt increments on ch_out's rising edge. Then -> PULSE_LO.
  - PULSE_LO: ch_out=0 for PERIOD-PULSE_W cycles. If ch_pulse_cnt<N_PULSES -> PULSE_HI, otherwise -> DONE.
  - DONE: entered at edge t0+DELAY+N_PULSES*PERIOD. ch_end_flg=1, ch_busy=0. Held until ch_start=0, then -> IDLE with ch_end_flg=0 on the following edge.
- Abort: ch_start=0 in any of DELAY_WAIT/PULSE_HI/PULSE_LO -> IDLE next edge; ch_out=0, ch_busy=0, ch_end_flg stays 0, ch_pulse_cnt frozen.
- Retrigger: no new burst until ch_start has been seen low and then rises again. A start edge while in DONE is impossible because ch_start must drop first.
- ch_pulse_cnt clears on the next trig, not when entering IDLE.
- ch_en changes mid-burst are ignored; ch_en is sampled only at trig.
- Counters:
  - Cycle counters count down from load value minus 1 to 0; the transition fires at 0.
  - No wrap: each counter is reloaded on every state entry.
- Parameter legality is checked at elaboration; an illegal combination is a fatal error.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package osg_pkg:
  - state enum osg_ch_state_t {IDLE, DELAY_WAIT, PULSE_HI, PULSE_LO, DONE};
  - localparam OSG_CNT_W=28;
  - localparam OSG_N_CH=16.
- One sub-module, osg_rise_det:
  - holds the start_d register with its reset-to-1 rule;
  - outputs a one-cycle trig pulse.
  - It is reused by the start controller's PC_start path.

Test Plan:
1. DELAY=3, PULSE_W=2, PERIOD=5, N_PULSES=3, ch_en=1, raise ch_start:
   - ch_out high at t0+3..t0+4, t0+8..t0+9, t0+13..t0+14;
   - ch_end_flg rises at t0+18; ch_pulse_cnt=3;
   - ch_start low -> ch_end_flg=0 one edge later.
2. Same params, drop ch_start at t0+9 (mid second pulse) -> ch_out=0 and IDLE at t0+10; ch_end_flg never rises; ch_pulse_cnt=2.
3. ch_en=0, raise ch_start -> no ch_out activity; ch_end_flg=1 at t0+1; ch_busy stays 0.
4. Hold ch_start=1 through reset release -> no pulses, ch_end_flg=0. Then lower and raise ch_start -> normal burst as in scenario 1.
5. Assert ch_rst_n=0 asynchronously at t0+8 (during pulse high) -> ch_out, ch_busy, ch_end_flg, ch_pulse_cnt all 0 immediately, without waiting for a clock edge.
6. Defaults, 16 instances driven by one start level plus the end-flag AND -> all ch_end_flg=1 at t0+50+4*50=t0+250; the AND output rises at the same edge.
